register_window: RTL and testbench

One SPARC-style register window: 8 local registers (r16–r23) and 8 in registers (r24–r31), with combinational read ports that assemble the full 32-register view. Globals (r0–r7) and outs (r8–r15) are stored outside the block and arrive as GA/GB and AxIn/BxIn. The block's ins are exported on AxOut/BxOut, where the adjacent window sees them as its outs. Instantiated once per window inside the register file.

---
 rtl/register_window.sv | 140 ++++++++++++++
 tb/tb_register_window.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_window.sv
// -----------------------------------------------------------------------------
// register_window
//
// One SPARC-style register window. Holds the 8 locals (r16-r23) and the
// 8 ins (r24-r31) of a single window and assembles the full 32-register view
// on two combinational read ports. Globals (r0-r7) and outs (r8-r15) live
// outside this block and arrive on GA/GB and AxIn/BxIn. The ins are exported
// on AxOut/BxOut, where the adjacent window sees them as its outs.
//
// Ports
//   Clk          clock; every register write happens on its rising edge
//   Rst_n        asynchronous active-low reset; clears all 16 registers
//   RA, RB [4:0] read addresses for ports A and B
//   RE     [7:0] one-hot (or broadcast) register-within-bank write select
//   WE           write enable for this window
//   BE3          ins bank select (r24-r31)
//   BE2          locals bank select (r16-r23)
//   BE1          outs bank select; qualifies cross-window writes (WEx)
//   WEx          cross-window write strobe from the neighbour writing its outs
//   in    [31:0] write data
//   GA, GB       global-register read data for ports A and B
//   AxIn, BxIn   neighbour's outs read data for ports A and B
//   Aout, Bout   read data for ports A and B
//   AxOut, BxOut ins[RA[2:0]] / ins[RB[2:0]], exported to the neighbour
//
// Configuration
//   RW_BYPASS_EN  when defined, a local or in register being written this
//                 cycle shows `in` on any output addressing it (write-through
//                 forwarding, suppressed while Rst_n is low). When undefined,
//                 outputs always reflect stored contents.
// -----------------------------------------------------------------------------
module register_window (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [4:0]  RA,
   input  logic [4:0]  RB,
   input  logic [7:0]  RE,
   input  logic        WE,
   input  logic        BE3,
   input  logic        BE2,
   input  logic        BE1,
   input  logic        WEx,
   input  logic [31:0] in,
   input  logic [31:0] GA,
   input  logic [31:0] GB,
   input  logic [31:0] AxIn,
   input  logic [31:0] BxIn,
   output logic [31:0] Aout,
   output logic [31:0] Bout,
   output logic [31:0] AxOut,
   output logic [31:0] BxOut
);

   // Bank select encoding on address bits [4:3]
   localparam logic [1:0] SEL_GLOBAL = 2'b00;
   localparam logic [1:0] SEL_OUTS   = 2'b01;
   localparam logic [1:0] SEL_LOCALS = 2'b10;
   localparam logic [1:0] SEL_INS    = 2'b11;

   logic [31:0] locals [8];
   logic [31:0] ins    [8];

   // Forwarding-adjusted views of the two banks; equal to storage when
   // bypass is not compiled in.
   logic [31:0] local_view [8];
   logic [31:0] ins_view   [8];

   logic [7:0] local_wr;
   logic [7:0] ins_wr;

   // Per-register write strobes. The ins can be written either by this
   // window (WE & BE3) or by the neighbour writing its outs (WEx & BE1);
   // both at once is a single write of the same data. WE & BE1 alone
   // targets the neighbour's storage and writes nothing here.
   assign local_wr = (WE && BE2) ? RE : 8'h00;
   assign ins_wr   = ((WE && BE3) || (WEx && BE1)) ? RE : 8'h00;

   // Storage. Reset wins over a same-edge write.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < 8; i++) begin
            locals[i] <= '0;
            ins[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (local_wr[i]) locals[i] <= in;
            if (ins_wr[i])   ins[i]    <= in;
         end
      end
   end

`ifdef RW_BYPASS_EN
   // Write-through: a register being written this cycle reads as `in`.
   // Gated by Rst_n so reset always presents cleared contents.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         local_view[i] = (Rst_n && local_wr[i]) ? in : locals[i];
         ins_view[i]   = (Rst_n && ins_wr[i])   ? in : ins[i];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         local_view[i] = locals[i];
         ins_view[i]   = ins[i];
      end
   end
`endif

   // Port A read mux
   always_comb begin
      Aout = GA;
      case (RA[4:3])
         SEL_GLOBAL: Aout = GA;
         SEL_OUTS:   Aout = AxIn;
         SEL_LOCALS: Aout = local_view[RA[2:0]];
         SEL_INS:    Aout = ins_view[RA[2:0]];
         default:    Aout = GA;
      endcase
   end

   // Port B read mux
   always_comb begin
      Bout = GB;
      case (RB[4:3])
         SEL_GLOBAL: Bout = GB;
         SEL_OUTS:   Bout = BxIn;
         SEL_LOCALS: Bout = local_view[RB[2:0]];
         SEL_INS:    Bout = ins_view[RB[2:0]];
         default:    Bout = GB;
      endcase
   end

   // Exported ins ignore the bank bits: the neighbour decodes its own
   // address and uses these only when it selects its outs.
   assign AxOut = ins_view[RA[2:0]];
   assign BxOut = ins_view[RB[2:0]];

endmodule

// File: tb/tb_register_window.sv
module tb_register_window;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic [4:0]  RA, RB;
   logic [7:0]  RE;
   logic        WE, BE3, BE2, BE1, WEx;
   logic [31:0] in, GA, GB, AxIn, BxIn;
   logic [31:0] Aout, Bout, AxOut, BxOut;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the window's half of the architectural register file,
   // indexed by architectural register number.
   logic [31:0] mem [16:31];

   register_window dut (
      .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .RE(RE), .WE(WE),
      .BE3(BE3), .BE2(BE2), .BE1(BE1), .WEx(WEx), .in(in),
      .GA(GA), .GB(GB), .AxIn(AxIn), .BxIn(BxIn),
      .Aout(Aout), .Bout(Bout), .AxOut(AxOut), .BxOut(BxOut)
   );

   // ---------------- clock / reset ----------------
   always #5 Clk = ~Clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Would architectural register `a` (16..31) be written at the next edge?
   function automatic bit being_written(int a);
      if (Rst_n !== 1'b1) return 0;
      if (a >= 16 && a < 24) return RE[a-16] && WE && BE2;
      if (a >= 24 && a < 32) return RE[a-24] && ((WE && BE3) || (WEx && BE1));
      return 0;
   endfunction

   function automatic logic [31:0] model_read(int a, logic [31:0] g, logic [31:0] x);
      if (a < 8)  return g;
      if (a < 16) return x;
`ifdef RW_BYPASS_EN
      if (being_written(a)) return in;
`endif
      return mem[a];
   endfunction

   task automatic check_outputs();
      check("Aout",  Aout,  model_read(int'(RA), GA, AxIn));
      check("Bout",  Bout,  model_read(int'(RB), GB, BxIn));
      check("AxOut", AxOut, model_read(24 + int'(RA[2:0]), GA, AxIn));
      check("BxOut", BxOut, model_read(24 + int'(RB[2:0]), GB, BxIn));
   endtask

   task automatic model_clear();
      for (int a = 16; a < 32; a++) mem[a] = '0;
   endtask

   // Apply the write rules of one rising edge to the model.
   task automatic model_edge();
      bit wr [16:31];
      for (int a = 16; a < 32; a++) wr[a] = being_written(a);
      for (int a = 16; a < 32; a++) if (wr[a]) mem[a] = in;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      WE = 0; BE3 = 0; BE2 = 0; BE1 = 0; WEx = 0; RE = 8'h00;
   endtask

   // Check combinational outputs mid-cycle, clock once, return at negedge.
   task automatic step();
      #1 check_outputs();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
   endtask

   task automatic random_inputs();
      WE  = 1'($urandom_range(0, 1));
      BE3 = 1'($urandom_range(0, 1));
      BE2 = 1'($urandom_range(0, 1));
      BE1 = 1'($urandom_range(0, 1));
      WEx = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0:       RE = 8'h00;
         1:       RE = 8'($urandom);
         default: RE = 8'h01 << $urandom_range(0, 7);
      endcase
      in   = $urandom;
      RA   = 5'($urandom_range(0, 31));
      RB   = 5'($urandom_range(0, 31));
      GA   = $urandom; GB = $urandom;
      AxIn = $urandom; BxIn = $urandom;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      in = '0; GA = '0; GB = '0; AxIn = '0; BxIn = '0;
      RA = 5'd31; RB = 5'd16;
      Rst_n = 1'b0;
      model_clear();

      // Reset
      #2;
      check("rst_Aout",  Aout,  32'h0);
      check("rst_Bout",  Bout,  32'h0);
      check("rst_AxOut", AxOut, 32'h0);
      GA = 32'h0BAD_F00D; RA = 5'd2;
      #1 check("rst_pass_GA", Aout, 32'h0BAD_F00D);
      RA = 5'd31;
      @(negedge Clk);
      Rst_n = 1'b1;
      step(); step();
      check("post_rst_Aout", Aout, 32'h0);

      // Ins write r31
      in = 32'h0000_1111; WE = 1; BE3 = 1; RE = 8'h80; RA = 5'd31;
      step();
      idle_inputs();
      #1 check("ins_w_Aout",  Aout,  32'h0000_1111);
      check("ins_w_AxOut", AxOut, 32'h0000_1111);
      RA = 5'd25;
      #1 check("ins_other", Aout, 32'h0);

      // Local write r18
      @(negedge Clk);
      in = 32'hDEAD_BEEF; WE = 1; BE2 = 1; RE = 8'h04; RB = 5'd18;
      step();
      idle_inputs();
      #1 check("loc_w_Bout", Bout, 32'hDEAD_BEEF);
      RB = 5'd26;
      #1 check("loc_ins_clean", Bout, 32'h0);

      // Pass-through
      GA = 32'hA5A5_A5A5; AxIn = 32'h1234_5678;
      RA = 5'd3;  #1 check("pass_GA", Aout, 32'hA5A5_A5A5);
      RA = 5'd9;  #1 check("pass_AxIn", Aout, 32'h1234_5678);

      // WE & BE1 alone writes nothing here
      @(negedge Clk);
      in = 32'h5555_0000; WE = 1; BE1 = 1; RE = 8'hFF;
      step();
      idle_inputs();
      RA = 5'd31; RB = 5'd16;
      #1 check("we_be1_ins", Aout, 32'h0000_1111);
      check("we_be1_loc", Bout, 32'h0);

      // Cross write ins[0]
      @(negedge Clk);
      in = 32'hCAFE_0001; WEx = 1; BE1 = 1; RE = 8'h01; RA = 5'd24;
      step();
      idle_inputs();
      #1 check("xw_Aout", Aout, 32'hCAFE_0001);
      @(negedge Clk);
      in = 32'hCAFE_0002; WEx = 1; BE1 = 0; RE = 8'h01;
      step();
      idle_inputs();
      #1 check("xw_noBE1", Aout, 32'hCAFE_0001);

      // Broadcast write to locals
      @(negedge Clk);
      in = 32'h7777_0007; WE = 1; BE2 = 1; RE = 8'hFF; RA = 5'd16; RB = 5'd23;
      step();
      idle_inputs();
      #1 check("bcast_r16", Aout, 32'h7777_0007);
      check("bcast_r23", Bout, 32'h7777_0007);

`ifdef RW_BYPASS_EN
      @(negedge Clk);
      in = 32'hB1B1_0031; WE = 1; BE3 = 1; RE = 8'h80; RA = 5'd31;
      #1 check("bypass_Aout", Aout, 32'hB1B1_0031);
      check("bypass_AxOut", AxOut, 32'hB1B1_0031);
      step();
      idle_inputs();
`endif

      // Randomized traffic against the model
      @(negedge Clk);
      for (int n = 0; n < 400; n++) begin
         random_inputs();
         step();
      end

      // Async reset mid-operation
      idle_inputs();
      in = 32'h0000_0001; WE = 1; BE3 = 1; RE = 8'h80; RA = 5'd31;
      step();
      idle_inputs();
      #1 check("pre_arst", Aout, 32'h0000_0001);
      #1 Rst_n = 1'b0;
      model_clear();
      #1 check("arst_Aout",  Aout,  32'h0);
      check("arst_AxOut", AxOut, 32'h0);
      // Reset has priority over a write at the edge it spans
      in = 32'h0000_00AA; WE = 1; BE3 = 1; RE = 8'h80;
      @(posedge Clk);
      @(negedge Clk);
      #1 check("rst_prio", Aout, 32'h0);
      check_outputs();
      idle_inputs();
      Rst_n = 1'b1;
      @(negedge Clk);
      for (int n = 0; n < 100; n++) begin
         random_inputs();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: the bench must always end on its own
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
